// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and helpers for the main-memory arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BURST = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CORE   = 1'b0,
        OWN_STREAM = 1'b1
    } owner_t;

    function automatic int burst_len_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - core, stream-engine and RAM signals seen by the arbiter
interface mem_arbiter_if #(
    parameter int MAIN_ADDR_WIDTH = 16,
    parameter int WORD_WIDTH      = 32,
    parameter int MAX_BURST       = 16
);
    import mem_arbiter_pkg::*;

    localparam int LEN_W = burst_len_width(MAX_BURST);

    logic                       core_write;
    logic [MAIN_ADDR_WIDTH-1:0] core_write_address;
    logic [WORD_WIDTH-1:0]      core_write_value;
    logic                       core_read;
    logic [MAIN_ADDR_WIDTH-1:0] core_read_address;
    logic                       core_stall;
    logic                       core_read_valid;
    logic [WORD_WIDTH-1:0]      core_read_data;

    logic                       stream_req;
    logic                       stream_dir;
    logic [MAIN_ADDR_WIDTH-1:0] stream_base;
    logic [LEN_W-1:0]           stream_len;
    logic                       stream_grant;
    logic                       stream_in_valid;
    logic [WORD_WIDTH-1:0]      stream_in_value;
    logic                       stream_in_ready;
    logic                       stream_out_valid;
    logic [WORD_WIDTH-1:0]      stream_out_value;
    logic                       stream_done;

    logic                       mem_we;
    logic                       mem_re;
    logic [MAIN_ADDR_WIDTH-1:0] mem_write_address;
    logic [MAIN_ADDR_WIDTH-1:0] mem_read_address;
    logic [WORD_WIDTH-1:0]      mem_write_value;
    logic [WORD_WIDTH-1:0]      mem_read_data;

    modport slave (
        input  core_write, core_write_address, core_write_value,
        input  core_read, core_read_address,
        output core_stall, core_read_valid, core_read_data,
        input  stream_req, stream_dir, stream_base, stream_len,
        output stream_grant,
        input  stream_in_valid, stream_in_value,
        output stream_in_ready, stream_out_valid, stream_out_value, stream_done,
        output mem_we, mem_re, mem_write_address, mem_read_address, mem_write_value,
        input  mem_read_data
    );

    modport master (
        output core_write, core_write_address, core_write_value,
        output core_read, core_read_address,
        input  core_stall, core_read_valid, core_read_data,
        output stream_req, stream_dir, stream_base, stream_len,
        input  stream_grant,
        output stream_in_valid, stream_in_value,
        input  stream_in_ready, stream_out_valid, stream_out_value, stream_done,
        input  mem_we, mem_re, mem_write_address, mem_read_address, mem_write_value,
        output mem_read_data
    );

endinterface

// File: rtl/mem_arb_return_pipe.sv
// rtl/mem_arb_return_pipe.sv - tags each RAM read with its owner until the data returns
module mem_arb_return_pipe
    import mem_arbiter_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   issue_valid,
    input  owner_t issue_owner,
    output logic   ret_valid,
    output owner_t ret_owner
);

    logic [DEPTH-1:0] valid_q;
    owner_t           owner_q [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                owner_q[i] <= OWN_CORE;
            end
        end else begin
            valid_q[0] <= issue_valid;
            owner_q[0] <= issue_owner;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                owner_q[i] <= owner_q[i-1];
            end
        end
    end

    assign ret_valid = valid_q[DEPTH-1];
    assign ret_owner = owner_q[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - core/stream RAM arbiter; MEM_ARB_STARVE_EN adds forced stream grants
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAIN_ADDR_WIDTH = 16,
    parameter int WORD_WIDTH      = 32,
    parameter int MAX_BURST       = 16,
    parameter int READ_LATENCY    = 1,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    localparam int LEN_W   = burst_len_width(MAX_BURST);
    localparam int DRAIN_W = $clog2(READ_LATENCY + 1);

    arb_state_t                 state_q, state_d;
    logic [MAIN_ADDR_WIDTH-1:0] base_q;
    logic [MAIN_ADDR_WIDTH-1:0] burst_addr;
    logic [LEN_W-1:0]           len_q;
    logic [LEN_W-1:0]           offset_q;
    logic                       dir_q;
    logic [DRAIN_W-1:0]         drain_q;

    logic   core_req;
    logic   len_ok;
    logic   starve_force;
    logic   grant;
    logic   burst_step;
    logic   last_word;
    logic   drain_last;
    logic   ret_valid;
    owner_t ret_owner;
    owner_t issue_owner;

    assign core_req   = bus.core_write | bus.core_read;
    assign len_ok     = bus.stream_len <= LEN_W'(MAX_BURST);
    assign grant      = !reset && (state_q == ARB_IDLE) && bus.stream_req && len_ok
                        && (!core_req || starve_force);
    assign burst_addr = base_q + MAIN_ADDR_WIDTH'(offset_q);
    assign burst_step = (state_q == ARB_BURST) && (!dir_q || bus.stream_in_valid);
    assign last_word  = offset_q == (len_q - LEN_W'(1));
    assign drain_last = drain_q == DRAIN_W'(READ_LATENCY - 1);

`ifdef MEM_ARB_STARVE_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] starve_q;

    // Counts only cycles where a grantable request lost to the core.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else if (grant) begin
            starve_q <= '0;
        end else if ((state_q == ARB_IDLE) && bus.stream_req && len_ok && core_req) begin
            starve_q <= starve_q + STARVE_W'(1);
        end
    end

    assign starve_force = starve_q >= STARVE_W'(STARVE_LIMIT);
`else
    // Strict core priority: the limit is only meaningful with starvation control built in.
    assign starve_force = 1'b0 & (STARVE_LIMIT != 0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            base_q   <= '0;
            len_q    <= '0;
            dir_q    <= 1'b0;
            offset_q <= '0;
            drain_q  <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                base_q   <= bus.stream_base;
                len_q    <= bus.stream_len;
                dir_q    <= bus.stream_dir;
                offset_q <= '0;
            end else if (burst_step) begin
                offset_q <= offset_q + LEN_W'(1);
            end
            drain_q <= (state_q == ARB_DRAIN) ? drain_q + DRAIN_W'(1) : '0;
        end
    end

    always_comb begin
        state_d               = state_q;
        issue_owner           = OWN_CORE;
        bus.core_stall        = 1'b0;
        bus.stream_in_ready   = 1'b0;
        bus.stream_done       = 1'b0;
        bus.mem_we            = 1'b0;
        bus.mem_re            = 1'b0;
        bus.mem_write_address = '0;
        bus.mem_read_address  = '0;
        bus.mem_write_value   = '0;

        case (state_q)
            ARB_IDLE: begin
                bus.mem_we            = bus.core_write;
                bus.mem_write_address = bus.core_write_address;
                bus.mem_write_value   = bus.core_write_value;
                bus.mem_re            = bus.core_read;
                bus.mem_read_address  = bus.core_read_address;
                // A zero-length burst is accepted and finished without leaving IDLE.
                if (grant) begin
                    if (bus.stream_len == '0) begin
                        bus.stream_done = 1'b1;
                    end else begin
                        state_d = ARB_BURST;
                    end
                end
            end
            ARB_BURST: begin
                bus.core_stall = core_req;
                if (dir_q) begin
                    bus.stream_in_ready   = 1'b1;
                    bus.mem_we            = bus.stream_in_valid;
                    bus.mem_write_address = burst_addr;
                    bus.mem_write_value   = bus.stream_in_value;
                    bus.stream_done       = bus.stream_in_valid && last_word;
                end else begin
                    bus.mem_re           = 1'b1;
                    bus.mem_read_address = burst_addr;
                    issue_owner          = OWN_STREAM;
                end
                if (burst_step && last_word) begin
                    state_d = dir_q ? ARB_IDLE : ARB_DRAIN;
                end
            end
            ARB_DRAIN: begin
                // Write port is idle while read data drains, so core writes proceed.
                bus.core_stall        = bus.core_read;
                bus.mem_we            = bus.core_write;
                bus.mem_write_address = bus.core_write_address;
                bus.mem_write_value   = bus.core_write_value;
                bus.stream_done       = drain_last;
                if (drain_last) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        if (reset) begin
            bus.core_stall        = 1'b0;
            bus.stream_in_ready   = 1'b0;
            bus.stream_done       = 1'b0;
            bus.mem_we            = 1'b0;
            bus.mem_re            = 1'b0;
            bus.mem_write_address = '0;
            bus.mem_read_address  = '0;
            bus.mem_write_value   = {WORD_WIDTH{1'b0}};
        end
    end

    assign bus.stream_grant = grant;

    mem_arb_return_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_return_pipe (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (bus.mem_re),
        .issue_owner (issue_owner),
        .ret_valid   (ret_valid),
        .ret_owner   (ret_owner)
    );

    assign bus.core_read_valid  = ret_valid && (ret_owner == OWN_CORE);
    assign bus.core_read_data   = bus.core_read_valid ? bus.mem_read_data : {WORD_WIDTH{1'b0}};
    assign bus.stream_out_valid = ret_valid && (ret_owner == OWN_STREAM);
    assign bus.stream_out_value = bus.stream_out_valid ? bus.mem_read_data : {WORD_WIDTH{1'b0}};

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a one-cycle RAM model
module tb_mem_arbiter;

    localparam int A   = 16;
    localparam int W   = 32;
    localparam int MB  = 16;
    localparam int LAT = 1;
    localparam int SL  = 8;

    typedef struct {
        logic [A-1:0] addr;
        logic [W-1:0] data;
        logic         chk_done;
        logic         done;
    } wr_t;

    typedef struct {
        logic [W-1:0] data;
        logic         done;
    } rd_t;

    logic clk;
    logic reset;

    int vectors     = 0;
    int miscompares = 0;

    wr_t exp_wr[$];
    rd_t exp_core[$];
    rd_t exp_sout[$];
    wr_t mon_wr;
    rd_t mon_rd;
    logic bare_done_ok = 1'b0;

    logic [W-1:0] ram [0:(1<<A)-1];
    logic         written [0:(1<<A)-1];
    logic [W-1:0] rd_q = '0;

    mem_arbiter_if #(.MAIN_ADDR_WIDTH(A), .WORD_WIDTH(W), .MAX_BURST(MB)) bus ();

    mem_arbiter #(
        .MAIN_ADDR_WIDTH (A),
        .WORD_WIDTH      (W),
        .MAX_BURST       (MB),
        .READ_LATENCY    (LAT),
        .STARVE_LIMIT    (SL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unwritten locations read back as {A5A5, address}.
    always @(posedge clk) begin
        if (bus.mem_we) begin
            ram[bus.mem_write_address]     <= bus.mem_write_value;
            written[bus.mem_write_address] <= 1'b1;
        end
        if (bus.mem_re) begin
            rd_q <= written[bus.mem_read_address] ? ram[bus.mem_read_address]
                                                  : {16'hA5A5, bus.mem_read_address};
        end
    end
    assign bus.mem_read_data = rd_q;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: DUT presented output, expected none", name);
    endtask

    task automatic push_wr(input logic [A-1:0] a, input logic [W-1:0] d,
                           input logic chk, input logic dn);
        wr_t e;
        e.addr = a; e.data = d; e.chk_done = chk; e.done = dn;
        exp_wr.push_back(e);
    endtask

    task automatic push_rd(input logic to_stream, input logic [W-1:0] d, input logic dn);
        rd_t e;
        e.data = d; e.done = dn;
        if (to_stream) exp_sout.push_back(e);
        else           exp_core.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.mem_we) begin
                if (exp_wr.size() == 0) unexpected("mem_write");
                else begin
                    mon_wr = exp_wr.pop_front();
                    check("mem_write_addr", 64'(bus.mem_write_address), 64'(mon_wr.addr));
                    check("mem_write_data", 64'(bus.mem_write_value), 64'(mon_wr.data));
                    if (mon_wr.chk_done) check("write_done", 64'(bus.stream_done), 64'(mon_wr.done));
                end
            end
            if (bus.core_read_valid) begin
                if (exp_core.size() == 0) unexpected("core_read_valid");
                else begin
                    mon_rd = exp_core.pop_front();
                    check("core_read_data", 64'(bus.core_read_data), 64'(mon_rd.data));
                end
            end
            if (bus.stream_out_valid) begin
                if (exp_sout.size() == 0) unexpected("stream_out_valid");
                else begin
                    mon_rd = exp_sout.pop_front();
                    check("stream_out_value", 64'(bus.stream_out_value), 64'(mon_rd.data));
                    check("stream_out_done", 64'(bus.stream_done), 64'(mon_rd.done));
                end
            end
            if (bus.stream_done && !bus.stream_out_valid && !(bus.mem_we && bus.stream_in_ready)
                && !bare_done_ok) unexpected("stream_done");
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int  grant_at;
        logic saw_grant;

        reset = 1'b1;
        bus.core_write = 1'b1; bus.core_write_address = 16'h0001; bus.core_write_value = 32'h1;
        bus.core_read = 1'b0;  bus.core_read_address = '0;
        bus.stream_req = 1'b0; bus.stream_dir = 1'b0; bus.stream_base = '0; bus.stream_len = '0;
        bus.stream_in_valid = 1'b0; bus.stream_in_value = '0;

        // Reset: outputs quiet even with a core request present.
        @(negedge clk);
        check("reset_mem_we", 64'(bus.mem_we), 64'd0);
        check("reset_ctrl", 64'({bus.core_stall, bus.stream_grant, bus.stream_in_ready,
              bus.stream_out_valid, bus.stream_done, bus.mem_re, bus.core_read_valid}), 64'd0);
        step();
        step();
        reset = 1'b0;
        bus.core_write = 1'b0;

        // Core only: write then read back.
        step();
        bus.core_write = 1'b1; bus.core_write_address = 16'h0010; bus.core_write_value = 32'hDEADBEEF;
        push_wr(16'h0010, 32'hDEADBEEF, 1'b0, 1'b0);
        @(negedge clk);
        check("core_write_stall", 64'(bus.core_stall), 64'd0);
        step();
        bus.core_write = 1'b0;
        bus.core_read = 1'b1; bus.core_read_address = 16'h0010;
        push_rd(1'b0, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        check("core_read_stall", 64'(bus.core_stall), 64'd0);
        step();
        bus.core_read = 1'b0;
        @(negedge clk);
        check("core_read_latency", 64'(bus.core_read_valid), 64'd1);

        // Write burst with 16-bit wrap; core write held across it stalls until IDLE.
        step();
        bus.stream_req = 1'b1; bus.stream_dir = 1'b1; bus.stream_base = 16'hFFFE; bus.stream_len = 5'd4;
        @(negedge clk);
        check("wburst_grant", 64'(bus.stream_grant), 64'd1);
        step();
        bus.stream_req = 1'b0;
        bus.stream_in_valid = 1'b1; bus.stream_in_value = 32'h0000_1000;
        push_wr(16'hFFFE, 32'h0000_1000, 1'b1, 1'b0);
        @(negedge clk);
        check("wburst_ready", 64'(bus.stream_in_ready), 64'd1);
        step();
        bus.stream_in_value = 32'h0000_1001;
        bus.core_write = 1'b1; bus.core_write_address = 16'h0020; bus.core_write_value = 32'h11112222;
        push_wr(16'hFFFF, 32'h0000_1001, 1'b1, 1'b0);
        @(negedge clk);
        check("wburst_core_stall", 64'(bus.core_stall), 64'd1);
        step();
        bus.stream_in_value = 32'h0000_1002;
        push_wr(16'h0000, 32'h0000_1002, 1'b1, 1'b0);
        step();
        bus.stream_in_value = 32'h0000_1003;
        push_wr(16'h0001, 32'h0000_1003, 1'b1, 1'b1);
        push_wr(16'h0020, 32'h11112222, 1'b0, 1'b0);
        @(negedge clk);
        check("wburst_done_last", 64'(bus.stream_done), 64'd1);
        step();
        bus.stream_in_valid = 1'b0;
        @(negedge clk);
        check("wburst_idle_stall", 64'(bus.core_stall), 64'd0);
        step();
        bus.core_write = 1'b0;

        // Read burst of 3; core write during DRAIN passes unstalled.
        step();
        bus.stream_req = 1'b1; bus.stream_dir = 1'b0; bus.stream_base = 16'h0400; bus.stream_len = 5'd3;
        @(negedge clk);
        check("rburst_grant", 64'(bus.stream_grant), 64'd1);
        step();
        bus.stream_req = 1'b0;
        push_rd(1'b1, 32'hA5A5_0400, 1'b0);
        push_rd(1'b1, 32'hA5A5_0401, 1'b0);
        push_rd(1'b1, 32'hA5A5_0402, 1'b1);
        @(negedge clk);
        check("rburst_issue", 64'({bus.mem_re, bus.mem_read_address}), 64'h1_0400);
        step();
        step();
        step();
        bus.core_write = 1'b1; bus.core_write_address = 16'h0030; bus.core_write_value = 32'hCAFEF00D;
        push_wr(16'h0030, 32'hCAFEF00D, 1'b0, 1'b0);
        @(negedge clk);
        check("drain_write_stall", 64'(bus.core_stall), 64'd0);
        check("drain_done", 64'(bus.stream_done), 64'd1);
        step();
        bus.core_write = 1'b0;

        // Starvation: core writes every cycle alongside a pending stream read.
        step();
        bus.stream_req = 1'b1; bus.stream_dir = 1'b0; bus.stream_base = 16'h0401; bus.stream_len = 5'd1;
        bus.core_write = 1'b1; bus.core_write_address = 16'h0050;
        grant_at = 0;
        for (int k = 1; k <= 20 && grant_at == 0; k++) begin
            bus.core_write_value = 32'h5000_0000 + 32'(k);
            push_wr(16'h0050, bus.core_write_value, 1'b0, 1'b0);
            @(negedge clk);
            if (bus.stream_grant) grant_at = k;
            step();
        end
        bus.stream_req = 1'b0;
`ifdef MEM_ARB_STARVE_EN
        check("starve_grant_cycle", 64'(grant_at), 64'd9);
        push_rd(1'b1, 32'hA5A5_0401, 1'b1);
        @(negedge clk);
        check("starve_burst_stall", 64'(bus.core_stall), 64'd1);
        step();
        bus.core_write_value = 32'h5000_00FF;
        push_wr(16'h0050, 32'h5000_00FF, 1'b0, 1'b0);
        @(negedge clk);
        check("starve_drain_stall", 64'(bus.core_stall), 64'd0);
        step();
`else
        check("strict_no_grant", 64'(grant_at), 64'd0);
`endif
        bus.core_write = 1'b0;

        // Reset during word 2 of a write burst, then a fresh burst.
        step();
        bus.stream_req = 1'b1; bus.stream_dir = 1'b1; bus.stream_base = 16'h0200; bus.stream_len = 5'd4;
        step();
        bus.stream_req = 1'b0;
        bus.stream_in_valid = 1'b1; bus.stream_in_value = 32'hA000_0001;
        push_wr(16'h0200, 32'hA000_0001, 1'b1, 1'b0);
        step();
        bus.stream_in_value = 32'hA000_0002;
        #1;
        reset = 1'b1;
        #1;
        check("rst_mid_ctrl", 64'({bus.core_stall, bus.stream_grant, bus.stream_in_ready,
              bus.stream_out_valid, bus.stream_done, bus.mem_we, bus.mem_re, bus.core_read_valid}), 64'd0);
        check("rst_mid_busses", 64'(|{bus.mem_write_address, bus.mem_read_address,
              bus.mem_write_value, bus.core_read_data, bus.stream_out_value}), 64'd0);
        bus.stream_in_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
        @(negedge clk);
        check("rst_idle_ready", 64'(bus.stream_in_ready), 64'd0);
        check("rst_word1_seen", 64'(exp_wr.size()), 64'd0);
        step();
        bus.stream_req = 1'b1; bus.stream_base = 16'h0300; bus.stream_len = 5'd2;
        step();
        bus.stream_req = 1'b0;
        bus.stream_in_valid = 1'b1; bus.stream_in_value = 32'hB000_0000;
        push_wr(16'h0300, 32'hB000_0000, 1'b1, 1'b0);
        step();
        bus.stream_in_value = 32'hB000_0001;
        push_wr(16'h0301, 32'hB000_0001, 1'b1, 1'b1);
        step();
        bus.stream_in_valid = 1'b0;

        // Zero-length burst: grant and done together, no RAM access.
        step();
        bus.stream_req = 1'b1; bus.stream_base = 16'h0500; bus.stream_len = 5'd0;
        bare_done_ok = 1'b1;
        @(negedge clk);
        check("len0_grant_done", 64'({bus.stream_grant, bus.stream_done}), 64'h3);
        check("len0_no_access", 64'({bus.mem_we, bus.mem_re}), 64'd0);
        step();
        bus.stream_req = 1'b0;
        bare_done_ok = 1'b0;
        @(negedge clk);
        check("len0_stays_idle", 64'(bus.stream_in_ready), 64'd0);

        // Over-long burst is never granted.
        step();
        bus.stream_req = 1'b1; bus.stream_len = 5'd17;
        saw_grant = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            saw_grant = saw_grant | bus.stream_grant;
            step();
        end
        check("len17_no_grant", 64'(saw_grant), 64'd0);
        bus.stream_req = 1'b0;

        step();
        step();
        step();
        check("exp_wr_drained", 64'(exp_wr.size()), 64'd0);
        check("exp_core_drained", 64'(exp_core.size()), 64'd0);
        check("exp_sout_drained", 64'(exp_sout.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
